// File: rtl/branch_target_predictor.sv
// IF-stage branch target predictor: direct-mapped BTB with one 2-bit
// saturating counter per entry, trained from the EX-stage branch resolution.
// Optional build macro BP_STATS_EN adds BrCount/MispredCount statistics outputs.
module branch_target_predictor #(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] INIT_CTR = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        BrValidE,
  input  logic        StallE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic [31:0] BrTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredE,
  output logic [31:0] RedirectPCE
`ifdef BP_STATS_EN
  ,
  output logic [31:0] BrCount,
  output logic [31:0] MispredCount
`endif
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  // Only the valid bits are reset; tag/target/counter contents are qualified by valid.
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [29:0]        tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // Fetch-side lookup: pre-update contents, no bypass from a same-cycle update.
  logic [IDX_W-1:0] idx_f;
  logic             hit_f;
  logic [31:0]      pcf_plus4;

  assign idx_f     = PCF[IDX_W+1:2];
  assign hit_f     = !rst && valid_q[idx_f] && (tag_q[idx_f] == PCF[31:IDX_W+2]);
  assign pcf_plus4 = PCF + 32'd4;

  assign PredTakenF  = hit_f && ctr_q[idx_f][1];
  assign PredTargetF = hit_f ? {tgt_q[idx_f], 2'b00} : pcf_plus4;

  // EX-side lookup used for training; a reset cycle drops the update.
  logic [IDX_W-1:0] idx_e;
  logic             hit_e;
  logic             upd;

  assign idx_e = PCE[IDX_W+1:2];
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == PCE[31:IDX_W+2]);
  assign upd   = BrValidE && !StallE && !rst;

  // Mispredict covers wrong direction and, for taken branches, wrong target.
  assign MispredE    = BrValidE && ((BranchE != PredTakenE) ||
                                    (BranchE && (PredTargetE != BrTargetE)));
  assign RedirectPCE = BranchE ? BrTargetE : (PCE + 32'd4);

  // Valid bits: cleared together on reset, set when a taken miss allocates.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (upd && !hit_e && BranchE) begin
      valid_q[idx_e] <= 1'b1;
    end
  end

  // Entry contents: counter/target training on hit, allocation on taken miss.
  always_ff @(posedge clk) begin
    if (upd) begin
      if (hit_e) begin
        if (BranchE) begin
          ctr_q[idx_e] <= ctr_inc(ctr_q[idx_e]);
          tgt_q[idx_e] <= BrTargetE[31:2];
        end else begin
          ctr_q[idx_e] <= ctr_dec(ctr_q[idx_e]);
        end
      end else if (BranchE) begin
        tag_q[idx_e] <= PCE[31:IDX_W+2];
        tgt_q[idx_e] <= BrTargetE[31:2];
        ctr_q[idx_e] <= INIT_CTR;
      end
    end
  end

`ifdef BP_STATS_EN
  // Statistics: resolved branches and mispredictions, wrapping at 2**32.
  always_ff @(posedge clk) begin
    if (rst) begin
      BrCount      <= '0;
      MispredCount <= '0;
    end else if (upd) begin
      BrCount <= BrCount + 32'd1;
      if (MispredE) begin
        MispredCount <= MispredCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed testbench for branch_target_predictor (default IDX_W=6, INIT_CTR=2'b10).
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BrValidE, StallE, BranchE, PredTakenE;
  logic [31:0] PCE, BrTargetE, PredTargetE;
  logic        MispredE;
  logic [31:0] RedirectPCE;
`ifdef BP_STATS_EN
  logic [31:0] BrCount, MispredCount;
`endif

  int checks   = 0;
  int failures = 0;

  branch_target_predictor dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .BrValidE(BrValidE), .StallE(StallE), .PCE(PCE), .BranchE(BranchE),
    .BrTargetE(BrTargetE), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredE(MispredE), .RedirectPCE(RedirectPCE)
`ifdef BP_STATS_EN
    , .BrCount(BrCount), .MispredCount(MispredCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; new inputs are applied 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic v, input logic [31:0] pc, input logic br,
                    input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    BrValidE = v; PCE = pc; BranchE = br; BrTargetE = tgt;
    PredTakenE = pt; PredTargetE = ptgt;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic tk, input logic [31:0] tgt);
    PCF = pc;
    #1;
    check({tag, "_taken"}, {31'd0, PredTakenF}, {31'd0, tk});
    check({tag, "_target"}, PredTargetF, tgt);
  endtask

  initial begin
    rst = 1'b1; StallE = 1'b0; PCF = 32'h100;
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    // Reset state and PC+4 wrap
    look("rst", 32'h100, 1'b0, 32'h104);
    check("rst_mispred", {31'd0, MispredE}, 32'd0);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    rst = 1'b0;
    tick();

    // Install a taken branch; same-cycle lookup sees old contents
    ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    look("nobypass", 32'h100, 1'b0, 32'h104);
    check("alloc_mispred", {31'd0, MispredE}, 32'd1);
    check("alloc_redirect", RedirectPCE, 32'h80);
    tick();
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("installed", 32'h100, 1'b1, 32'h80);

    // Not-taken twice: 10 -> 01 -> 00, entry retained
    ex(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    check("nt_mispred", {31'd0, MispredE}, 32'd1);
    check("nt_redirect", RedirectPCE, 32'h104);
    tick();
    look("ctr01", 32'h100, 1'b0, 32'h80);
    tick();
    look("ctr00", 32'h100, 1'b0, 32'h80);
    tick();  // third not-taken: stays at 00
    // Taken: 00 -> 01 -> 10 -> 11 -> 11
    ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick();
    look("ctr_up01", 32'h100, 1'b0, 32'h80);
    tick();
    look("ctr_up10", 32'h100, 1'b1, 32'h80);
    tick();
    tick();
    // One not-taken from saturated 11 lands on 10 (still taken)
    ex(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    tick();
    look("sat_dec", 32'h100, 1'b1, 32'h80);

    // Target change on taken hit; mispredict on wrong target, none when correct
    ex(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h80);
    #1;
    check("tgt_mispred", {31'd0, MispredE}, 32'd1);
    tick();
    ex(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    look("tgt_update", 32'h100, 1'b1, 32'h200);
    check("correct_pred", {31'd0, MispredE}, 32'd0);
    ex(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    #1;
    check("novalid_mispred", {31'd0, MispredE}, 32'd0);

    // Aliasing: 0x100 + 4*64 evicts 0x100
    ex(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    tick();
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("alias_old", 32'h100, 1'b0, 32'h104);
    look("alias_new", 32'h200, 1'b1, 32'h300);

    // Stall blocks training but MispredE is still evaluated
    StallE = 1'b1;
    ex(1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 32'h404);
    #1;
    check("stall_mispred", {31'd0, MispredE}, 32'd1);
    tick();
    StallE = 1'b0;
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("stall_noalloc", 32'h400, 1'b0, 32'h404);

    // Not-taken miss does not allocate
    ex(1'b1, 32'h600, 1'b0, 32'h700, 1'b0, 32'h604);
    tick();
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("nt_noalloc", 32'h600, 1'b0, 32'h604);

    // Reset with a branch in EX: update dropped, existing entries invalidated
    rst = 1'b1;
    ex(1'b1, 32'h700, 1'b1, 32'h900, 1'b0, 32'h704);
    look("rst_gate", 32'h200, 1'b0, 32'h204);
    check("rst_mispred_ex", {31'd0, MispredE}, 32'd1);
    tick();
    rst = 1'b0;
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("rst_drop", 32'h700, 1'b0, 32'h704);
    look("rst_clear", 32'h200, 1'b0, 32'h204);

`ifdef BP_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("stats_rst_br", BrCount, 32'd0);
    check("stats_rst_mp", MispredCount, 32'd0);
    ex(1'b1, 32'h800, 1'b1, 32'h880, 1'b0, 32'h804); tick();  // mispredicted
    ex(1'b1, 32'h800, 1'b1, 32'h880, 1'b1, 32'h880); tick();  // correct
    ex(1'b1, 32'h900, 1'b0, 32'h0,   1'b0, 32'h904); tick();  // correct
    ex(1'b1, 32'h800, 1'b0, 32'h880, 1'b1, 32'h880); tick();  // mispredicted
    ex(1'b1, 32'hA00, 1'b0, 32'h0,   1'b0, 32'hA04); tick();  // correct
    StallE = 1'b1;
    ex(1'b1, 32'hB00, 1'b1, 32'hC00, 1'b0, 32'hB04); tick();  // stalled: not counted
    StallE = 1'b0;
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("stats_br", BrCount, 32'd5);
    check("stats_mp", MispredCount, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("stats_rst2_br", BrCount, 32'd0);
    check("stats_rst2_mp", MispredCount, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
